synaptic_integrator: RTL and testbench

//  Reader side of the Hebbian weight matrix: consumes weights_flat as written by the

---
 rtl/synaptic_integrator_if.sv | 15 +
 rtl/synaptic_integrator.sv | 92 +++++++++
 tb/tb_synaptic_integrator.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/synaptic_integrator_if.sv
// Port bundle between the synaptic integrator and its driver.
// The driver supplies the spike vector, the weight matrix and start; the integrator returns currents and status.
interface synaptic_integrator_if #(parameter int N = 7);
  logic                  start;
  logic [N-1:0]          spikes;
  logic [N*N*16-1:0]     weights_flat;
  logic [N*16-1:0]       currents_flat;
  logic                  busy;
  logic                  current_valid;

  modport master (output start, spikes, weights_flat,
                  input  currents_flat, busy, current_valid);
  modport slave  (input  start, spikes, weights_flat,
                  output currents_flat, busy, current_valid);
endinterface

// File: rtl/synaptic_integrator.sv
// Sequential synaptic current integrator: I[j] = sum_{i!=j} spike[i]*W[i][j].
// The integrator handles one matrix term per cycle, with pre (i) as the inner loop and post (j) as the outer loop.
module synaptic_integrator #(
  parameter int N = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  synaptic_integrator_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 16 + CW;
  localparam int IW = $clog2(N*N);
  localparam logic signed [AW-1:0] S_MAX = AW'(32767);
  localparam logic signed [AW-1:0] S_MIN = AW'(-32768);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         pre_cnt, post_cnt;
  logic signed [AW-1:0]  acc, sum;
  logic [N-1:0]          spk_q;
  logic [N-1:0][15:0]    cur_q;
  logic                  valid_q;
  logic [N*N-1:0][15:0]  w_arr;
  logic [IW-1:0]         w_idx;
  logic [15:0]           term, sat;
  logic                  accept, last_pre, last_post;

  assign w_arr     = bus.weights_flat;
  assign w_idx     = IW'(pre_cnt) * IW'(N) + IW'(post_cnt);
  assign accept    = (state == IDLE) && bus.start;
  assign last_pre  = (pre_cnt  == CW'(N-1));
  assign last_post = (post_cnt == CW'(N-1));

  // The diagonal self-synapse is never summed, whatever its weight or spike.
  assign term = (spk_q[pre_cnt] && (pre_cnt != post_cnt)) ? w_arr[w_idx] : 16'h0000;
  assign sum  = acc + {{CW{term[15]}}, term};
  assign sat  = (sum > S_MAX) ? 16'h7fff :
                (sum < S_MIN) ? 16'h8000 : sum[15:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SCAN;
      SCAN:    if (last_pre && last_post) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt  <= '0;
      post_cnt <= '0;
      acc      <= '0;
      spk_q    <= '0;
      cur_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        spk_q    <= bus.spikes;
        pre_cnt  <= '0;
        post_cnt <= '0;
        acc      <= '0;
      end else if (state == SCAN) begin
        if (!last_pre) begin
          acc     <= sum;
          pre_cnt <= pre_cnt + CW'(1);
        end else begin
          cur_q[post_cnt] <= sat;
          acc             <= '0;
          pre_cnt         <= '0;
          if (!last_post) begin
            post_cnt <= post_cnt + CW'(1);
          end else begin
            post_cnt <= '0;
            valid_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.busy          = (state == SCAN);
  assign bus.current_valid = valid_q;
  assign bus.currents_flat = cur_q;
endmodule

// File: tb/tb_synaptic_integrator.sv
// Self-checking bench for synaptic_integrator: directed table passes, handshake corners and random passes.
// The random passes are checked against a plain-arithmetic model of the current sums.
module tb_synaptic_integrator;
  localparam int N  = 7;
  localparam int NN = N*N;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vecs = 0;
  int   miss = 0;
  int   wm [N][N];

  synaptic_integrator_if #(.N(N)) bus ();
  synaptic_integrator #(.N(N)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    int               wmode;   // 0 all +1, 1 W=i*7+j, 2 all +32767, 3 all -32768
    logic [N-1:0]     spk;
    logic [N*16-1:0]  exp;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [N*16-1:0] act, input logic [N*16-1:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_w();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.weights_flat[((i*N+j)*16) +: 16] = 16'(wm[i][j]);
  endtask

  function automatic logic [N*16-1:0] model(input logic [N-1:0] spk);
    logic [N*16-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < N; i++)
        if (spk[i] && i != j) s += wm[i][j];
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      r[j*16 +: 16] = 16'(s);
    end
    return r;
  endfunction

  // Start one pass; spikes switches to spk_after right after acceptance.
  task automatic run_pass(input logic [N-1:0] spk, input logic [N-1:0] spk_after,
                          output int lat, output int bcnt);
    @(negedge clk);
    bus.spikes = spk;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.spikes = spk_after;
    lat = 0; bcnt = 0;
    while (!bus.current_valid && lat < 200) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, nvalid;
    logic [N*16-1:0] e;

    tbl[0] = '{"all_ones",  0, 7'b1111111, {N{16'sd6}}};
    tbl[1] = '{"ramp_0b101", 1, 7'b0000101,
               {16'd26, 16'd24, 16'd22, 16'd20, 16'd2, 16'd16, 16'd14}};
    tbl[2] = '{"sat_pos",   2, 7'b1111111, {N{16'h7fff}}};
    tbl[3] = '{"sat_neg",   3, 7'b1111111, {N{16'h8000}}};
    tbl[4] = '{"no_spikes", 2, 7'b0000000, {N{16'h0000}}};

    bus.start = 1'b0;
    bus.spikes = '0;
    bus.weights_flat = '0;

    // Reset with start held high must not launch a pass.
    bus.start = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_currents", bus.currents_flat, '0);
    chk("rst_busy",     N*16'(bus.busy), '0);
    chk("rst_valid",    N*16'(bus.current_valid), '0);
    bus.start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", N*16'(bus.busy), '0);

    foreach (tbl[t]) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          case (tbl[t].wmode)
            0: wm[i][j] = 1;
            1: wm[i][j] = i*7 + j;
            2: wm[i][j] = 32767;
            default: wm[i][j] = -32768;
          endcase
      load_w();
      run_pass(tbl[t].spk, ~tbl[t].spk, lat, bcnt);
      chk({tbl[t].name, "_lat"},  N*16'(lat),  N*16'(NN));
      chk({tbl[t].name, "_busy"}, N*16'(bcnt), N*16'(NN));
      chk({tbl[t].name, "_I"},    bus.currents_flat, tbl[t].exp);
      @(negedge clk);
      chk({tbl[t].name, "_pulse"}, N*16'(bus.current_valid), '0);
    end

    // A start pulse during a pass is ignored: exactly one valid pulse.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = i - j;
    load_w();
    @(negedge clk); bus.spikes = 7'b1011011; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    nvalid = 0;
    repeat (120) begin
      if (bus.current_valid) nvalid++;
      @(negedge clk);
    end
    chk("ignore_start_nvalid", N*16'(nvalid), N*16'(1));
    chk("ignore_start_I", bus.currents_flat, model(7'b1011011));

    // Start held through the valid cycle: second pass is accepted on that edge.
    bus.spikes = 7'b1100110; bus.start = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!bus.current_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("b2b_first_I", bus.currents_flat, model(7'b1100110));
    bus.spikes = 7'b0011001;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy_again", N*16'(bus.busy), N*16'(1));
    lat = 1;
    while (!bus.current_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("b2b_gap", N*16'(lat), N*16'(NN+1));
    chk("b2b_second_I", bus.currents_flat, model(7'b0011001));

    // Reset 20 cycles into a pass aborts immediately with no valid pulse.
    @(negedge clk); bus.spikes = 7'b1111111; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_currents", bus.currents_flat, '0);
    chk("midrst_busy",  N*16'(bus.busy), '0);
    chk("midrst_valid", N*16'(bus.current_valid), '0);
    @(negedge clk); reset_n = 1'b1;
    nvalid = 0;
    repeat (60) begin
      if (bus.current_valid || bus.busy) nvalid++;
      @(negedge clk);
    end
    chk("midrst_no_activity", N*16'(nvalid), '0);

    // Random weights (biased toward the extremes) and random spike vectors.
    for (int r = 0; r < 10; r++) begin
      logic [N-1:0] s;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          case ($urandom_range(0, 3))
            0: wm[i][j] = 32767 - int'($urandom_range(0, 15));
            1: wm[i][j] = -32768 + int'($urandom_range(0, 15));
            default: wm[i][j] = int'($urandom_range(0, 65535)) - 32768;
          endcase
      load_w();
      s = N'($urandom);
      e = model(s);
      run_pass(s, N'($urandom), lat, bcnt);
      chk($sformatf("rand%0d_lat", r), N*16'(lat), N*16'(NN));
      chk($sformatf("rand%0d_I", r), bus.currents_flat, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
